// File: rtl/pbuf_pkg.sv
// Shared definitions for pattern-buffer access: field offsets, FSM states, index width.
package pbuf_pkg;

    localparam int unsigned FIELD_W = 5;
    localparam int unsigned CNT_W   = 3;

    // Field offsets inside one pattern buffer (P side 0..11, N side 12..21).
    localparam int unsigned PDRIVE      = 0;
    localparam int unsigned NDRIVE      = 1;
    localparam int unsigned PTWEAKSENSE = 2;
    localparam int unsigned PTWEAKRSVD  = 3;   // unnamed slot between sense and tweak bits
    localparam int unsigned PTWEAK0     = 4;
    localparam int unsigned PTWEAK7     = 11;
    localparam int unsigned NTWEAKSENSE = 12;
    localparam int unsigned NTWEAKRSVD  = 13;
    localparam int unsigned NTWEAK0     = 14;
    localparam int unsigned NTWEAK7     = 21;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETBUF = 2'd1,
        SETFLD = 2'd2,
        WAIT   = 2'd3
    } pbuf_state_t;

endpackage

// File: rtl/pbuf_onehot.sv
// Field index to one-hot field pointer; all-zero for indices past WIDTH-1.
module pbuf_onehot
    import pbuf_pkg::*;
#(
    parameter int unsigned WIDTH = 22
) (
    input  logic [FIELD_W-1:0] field_i,
    output logic [WIDTH-1:0]   onehot_c
);

    // Decode: bit i set only when the index equals i.
    always_comb begin
        onehot_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            onehot_c[i] = (32'(field_i) == i);
        end
    end

endmodule

// File: rtl/pbuf_access.sv
// Command front-end for the pattern buffers: sets buffer/field pointers, issues
// writes, and times reads against the buffer's fixed read latency.
// Optional macro PBUF_ACCESS_WRITE_VERIFY_EN: read back every write and flag a
// mismatch on err.
module pbuf_access
    import pbuf_pkg::*;
#(
    parameter int unsigned BUF_SIZE  = 22,
    parameter int unsigned BUF_WIDTH = 8,
    parameter int unsigned NO_BUFS   = 8,
    parameter int unsigned READ_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic                 cmd_burst,
    input  logic [2:0]           cmd_buf,
    input  logic [FIELD_W-1:0]   cmd_field,
    input  logic [BUF_WIDTH-1:0] cmd_data,
    output logic                 rsp_valid,
    output logic [BUF_WIDTH-1:0] rsp_data,
    output logic [FIELD_W-1:0]   rsp_field,
    output logic                 rsp_last,
    output logic                 err,
    output logic [2:0]           bufp_out,
    output logic [BUF_SIZE-1:0]  fieldp_out,
    output logic [BUF_SIZE-1:0]  fieldwp_out,
    output logic [BUF_WIDTH-1:0] field_out,
    output logic                 field_write_out,
    input  logic [BUF_WIDTH-1:0] field_byte_in
);

    pbuf_state_t          state_q, state_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 write_q, write_d;
    logic                 burst_q, burst_d;
    logic                 verify_q, verify_d;
    logic [2:0]           buf_q, buf_d;
    logic [FIELD_W-1:0]   field_q, field_d;
    logic [BUF_WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [BUF_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [FIELD_W-1:0]   rsp_field_q, rsp_field_d;
    logic                 rsp_last_q, rsp_last_d;
    logic                 err_q, err_d;
    logic [2:0]           bufp_q, bufp_d;
    logic [BUF_SIZE-1:0]  fieldp_q, fieldp_d;
    logic [BUF_SIZE-1:0]  fieldwp_q, fieldwp_d;
    logic [BUF_WIDTH-1:0] field_out_q, field_out_d;
    logic                 field_write_q, field_write_d;
    logic [BUF_SIZE-1:0]  field_onehot_c;

    pbuf_onehot #(.WIDTH(BUF_SIZE)) u_onehot (
        .field_i  (field_q),
        .onehot_c (field_onehot_c)
    );

    // Next-state and registered-output logic; pointers only move in SETBUF/SETFLD.
    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        burst_d       = burst_q;
        verify_d      = verify_q;
        buf_d         = buf_q;
        field_d       = field_q;
        data_d        = data_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data_q;
        rsp_field_d   = rsp_field_q;
        rsp_last_d    = 1'b0;
        err_d         = 1'b0;
        bufp_d        = bufp_q;
        fieldp_d      = fieldp_q;
        fieldwp_d     = fieldwp_q;
        field_out_d   = field_out_q;
        field_write_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    write_d  = cmd_write;
                    burst_d  = cmd_burst;
                    buf_d    = cmd_buf;
                    field_d  = cmd_field;
                    data_d   = cmd_data;
                    verify_d = 1'b0;
                    if (32'(cmd_field) >= BUF_SIZE || 32'(cmd_buf) >= NO_BUFS) begin
                        err_d = 1'b1;
                    end else if (cmd_buf != bufp_q) begin
                        state_d = SETBUF;
                    end else begin
                        state_d = SETFLD;
                    end
                end
            end
            SETBUF: begin
                bufp_d  = buf_q;
                state_d = SETFLD;
            end
            SETFLD: begin
                if (write_q) begin
                    fieldwp_d     = field_onehot_c;
                    field_out_d   = data_q;
                    field_write_d = 1'b1;
`ifdef PBUF_ACCESS_WRITE_VERIFY_EN
                    fieldp_d = field_onehot_c;
                    cnt_d    = CNT_W'(READ_LAT);
                    verify_d = 1'b1;
                    state_d  = WAIT;
`else
                    state_d = IDLE;
`endif
                end else begin
                    fieldp_d = field_onehot_c;
                    cnt_d    = CNT_W'(READ_LAT);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (verify_q) begin
                    err_d   = (field_byte_in != data_q);
                    state_d = IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = field_byte_in;
                    rsp_field_d = field_q;
                    if (burst_q && 32'(field_q) < BUF_SIZE - 1) begin
                        field_d = field_q + FIELD_W'(1);
                        state_d = SETFLD;
                    end else begin
                        rsp_last_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    // State and output registers; reset drops any command in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            write_q       <= 1'b0;
            burst_q       <= 1'b0;
            verify_q      <= 1'b0;
            buf_q         <= '0;
            field_q       <= '0;
            data_q        <= '0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_field_q   <= '0;
            rsp_last_q    <= 1'b0;
            err_q         <= 1'b0;
            bufp_q        <= '0;
            fieldp_q      <= '0;
            fieldwp_q     <= '0;
            field_out_q   <= '0;
            field_write_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            write_q       <= write_d;
            burst_q       <= burst_d;
            verify_q      <= verify_d;
            buf_q         <= buf_d;
            field_q       <= field_d;
            data_q        <= data_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_field_q   <= rsp_field_d;
            rsp_last_q    <= rsp_last_d;
            err_q         <= err_d;
            bufp_q        <= bufp_d;
            fieldp_q      <= fieldp_d;
            fieldwp_q     <= fieldwp_d;
            field_out_q   <= field_out_d;
            field_write_q <= field_write_d;
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_field       = rsp_field_q;
    assign rsp_last        = rsp_last_q;
    assign err             = err_q;
    assign bufp_out        = bufp_q;
    assign fieldp_out      = fieldp_q;
    assign fieldwp_out     = fieldwp_q;
    assign field_out       = field_out_q;
    assign field_write_out = field_write_q;

endmodule

// File: tb/tb_pbuf_access.sv
// Bench for pbuf_access: pattern-buffer model with read latency, transaction
// scoreboard checked every cycle, and directed timing checks.
module tb_pbuf_access;

    localparam int unsigned BS  = 22;
    localparam int unsigned BW  = 8;
    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write, cmd_burst;
    logic [2:0]    cmd_buf;
    logic [4:0]    cmd_field;
    logic [BW-1:0] cmd_data;
    logic          rsp_valid, rsp_last, err, field_write_out;
    logic [BW-1:0] rsp_data, field_out, field_byte_in;
    logic [4:0]    rsp_field;
    logic [2:0]    bufp_out;
    logic [BS-1:0] fieldp_out, fieldwp_out;

    pbuf_access #(.BUF_SIZE(BS), .BUF_WIDTH(BW), .NO_BUFS(8), .READ_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_burst(cmd_burst), .cmd_buf(cmd_buf), .cmd_field(cmd_field), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_field(rsp_field), .rsp_last(rsp_last),
        .err(err), .bufp_out(bufp_out), .fieldp_out(fieldp_out), .fieldwp_out(fieldwp_out),
        .field_out(field_out), .field_write_out(field_write_out), .field_byte_in(field_byte_in)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] data; logic [4:0] field; logic last; } rsp_t;
    typedef struct packed { logic [2:0] b; logic [4:0] field; logic [7:0] data; } wr_t;

    rsp_t   exp_rsp[$];
    rsp_t   rsp_log[$];
    wr_t    exp_wr[$];
    int     err_pending = 0;
    int     n_cmp = 0;
    int     n_bad = 0;
    bit     corrupt = 1'b0;

    logic [7:0] mem     [8][BS];
    logic [7:0] ref_mem [8][BS];
    bit         mem_ready = 1'b0;
    logic [7:0] dly;

    function automatic logic [7:0] init_byte(input int b, input int f);
        return 8'(b * 32 + f) ^ 8'h5A;
    endfunction

    function automatic int oh_idx(input logic [BS-1:0] v);
        for (int i = 0; i < BS; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at %0t", name, $time);
    endfunction

    // Pattern buffer: writes on strobe, read data appears READ_LAT cycles after the pointer.
    always @(posedge clk) begin
        int wi, ri;
        if (!mem_ready) begin
            for (int b = 0; b < 8; b++)
                for (int f = 0; f < BS; f++) mem[b][f] <= init_byte(b, f);
            mem_ready <= 1'b1;
        end else if (field_write_out) begin
            wi = oh_idx(fieldwp_out);
            if (wi >= 0) mem[bufp_out][wi] <= field_out;
        end
        ri  = oh_idx(fieldp_out);
        dly <= (ri >= 0) ? mem[bufp_out][ri] : 8'h00;
    end
    assign field_byte_in = dly ^ BW'(corrupt);

    // Scoreboard: every strobe must match the next expected transaction.
    logic [2:0]    prev_b;
    logic [BS-1:0] prev_p, prev_wp;
    always @(negedge clk) begin
        rsp_t r;
        wr_t  w;
        if (!reset) begin
            if (rsp_valid) begin
                rsp_log.push_back({rsp_data, rsp_field, rsp_last});
                if (exp_rsp.size() == 0) flag("unexpected_rsp_valid");
                else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_data", 32'(rsp_data), 32'(r.data));
                    chk("rsp_field", 32'(rsp_field), 32'(r.field));
                    chk("rsp_last", 32'(rsp_last), 32'(r.last));
                end
            end
            if (field_write_out) begin
                if (exp_wr.size() == 0) flag("unexpected_write");
                else begin
                    w = exp_wr.pop_front();
                    chk("wr_bufp", 32'(bufp_out), 32'(w.b));
                    chk("wr_fieldwp", 32'(fieldwp_out), 32'(1) << w.field);
                    chk("wr_data", 32'(field_out), 32'(w.data));
                end
            end
            if (err) begin
                if (err_pending == 0) flag("unexpected_err");
                else err_pending--;
            end
            chk("ptr_same_cycle", 32'((bufp_out != prev_b) &&
                ((fieldp_out != prev_p) || (fieldwp_out != prev_wp))), 32'(0));
            chk("fieldp_onehot", 32'($countones(fieldp_out) <= 1), 32'(1));
        end
        prev_b  = bufp_out;
        prev_p  = fieldp_out;
        prev_wp = fieldwp_out;
    end

    task automatic issue(input bit wr, input bit burst, input logic [2:0] b,
                         input logic [4:0] f, input logic [7:0] d);
        int t = 0;
        while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) flag("issue_timeout");
        if (32'(f) >= BS) err_pending++;
        else if (wr) begin
            exp_wr.push_back({b, f, d});
            ref_mem[b][f] = d;
`ifdef PBUF_ACCESS_WRITE_VERIFY_EN
            if (corrupt) err_pending++;
`endif
        end else begin
            for (int i = int'(f); i < (burst ? BS : int'(f) + 1); i++)
                exp_rsp.push_back({ref_mem[b][i], 5'(i), i == (burst ? BS - 1 : int'(f))});
        end
        cmd_write = wr; cmd_burst = burst; cmd_buf = b; cmd_field = f; cmd_data = d;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(cmd_ready && exp_rsp.size() == 0 && exp_wr.size() == 0 && err_pending == 0)
               && t < 300) begin
            @(negedge clk); t++;
        end
        if (t >= 300) flag("wait_idle_timeout");
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bufp"}, 32'(bufp_out), 0);
        chk({tag, "_fieldp"}, 32'(fieldp_out), 0);
        chk({tag, "_fieldwp"}, 32'(fieldwp_out), 0);
        chk({tag, "_field_out"}, 32'(field_out), 0);
        chk({tag, "_fwrite"}, 32'(field_write_out), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_last"}, 32'(rsp_last), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
        chk({tag, "_rsp_field"}, 32'(rsp_field), 0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int b = 0; b < 8; b++)
            for (int f = 0; f < BS; f++) ref_mem[b][f] = init_byte(b, f);
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_burst = 1'b0;
        cmd_buf = '0; cmd_field = '0; cmd_data = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);

        // Write buf 3 field 5: buffer pointer first, field pointer and strobe one cycle later.
        issue(1'b1, 1'b0, 3'd3, 5'd5, 8'hA5);
        chk("w_accept_bufp", 32'(bufp_out), 0);
        @(negedge clk);
        chk("w_setbuf_bufp", 32'(bufp_out), 3);
        chk("w_setbuf_fieldwp", 32'(fieldwp_out), 0);
        chk("w_setbuf_fwrite", 32'(field_write_out), 0);
        @(negedge clk);
        chk("w_setfld_fieldwp", 32'(fieldwp_out), 32'h20);
        chk("w_setfld_data", 32'(field_out), 32'hA5);
        chk("w_setfld_fwrite", 32'(field_write_out), 1);
        @(negedge clk);
        chk("w_done_fwrite", 32'(field_write_out), 0);
`ifndef PBUF_ACCESS_WRITE_VERIFY_EN
        chk("w_done_ready", 32'(cmd_ready), 1);
`endif
        wait_idle();

        // Single read, same buffer: no SETBUF, response READ_LAT cycles after pointer.
        issue(1'b0, 1'b0, 3'd3, 5'd5, 8'h00);
        @(negedge clk);
        chk("r_fieldp", 32'(fieldp_out), 32'h20);
        chk("r_bufp", 32'(bufp_out), 3);
        chk("r_early_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("r_early_valid2", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("r_valid", 32'(rsp_valid), 1);
        chk("r_data", 32'(rsp_data), 32'hA5);
        chk("r_field", 32'(rsp_field), 5);
        chk("r_last", 32'(rsp_last), 1);
        wait_idle();

        // Burst from field 19 of buffer 0.
        rsp_log.delete();
        issue(1'b0, 1'b1, 3'd0, 5'd19, 8'h00);
        wait_idle();
        chk("burst_count", 32'(rsp_log.size()), 3);
        if (rsp_log.size() == 3) begin
            chk("burst0", 32'(rsp_log[0]), 32'({8'h49, 5'd19, 1'b0}));
            chk("burst1", 32'(rsp_log[1]), 32'({8'h4E, 5'd20, 1'b0}));
            chk("burst2", 32'(rsp_log[2]), 32'({8'h4F, 5'd21, 1'b1}));
        end
        chk("burst_bufp", 32'(bufp_out), 0);

        // Illegal field: err pulse only, pointers untouched, ready stays high.
        issue(1'b0, 1'b0, 3'd5, 5'd22, 8'h00);
        chk("ill_err", 32'(err), 1);
        chk("ill_ready", 32'(cmd_ready), 1);
        chk("ill_bufp", 32'(bufp_out), 0);
        chk("ill_fieldp", 32'(fieldp_out), 32'h200000);
        @(negedge clk);
        chk("ill_err_clear", 32'(err), 0);

        // Command offered while busy must be ignored.
        issue(1'b0, 1'b1, 3'd1, 5'd10, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("busy_ready_low", 32'(cmd_ready), 0);
        cmd_write = 1'b1; cmd_buf = 3'd2; cmd_field = 5'd3; cmd_data = 8'h77; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle();
        chk("ignored_cmd_mem", 32'(mem[2][3]), 32'h19);

        // Mixed traffic.
        issue(1'b1, 1'b0, 3'd1, 5'd0, 8'h11);   wait_idle();
        issue(1'b1, 1'b0, 3'd1, 5'd21, 8'hEE);  wait_idle();
        issue(1'b1, 1'b0, 3'd7, 5'd0, 8'h80);   wait_idle();
        issue(1'b0, 1'b0, 3'd1, 5'd21, 8'h00);  wait_idle();
        issue(1'b0, 1'b1, 3'd1, 5'd20, 8'h00);  wait_idle();
        issue(1'b0, 1'b0, 3'd7, 5'd0, 8'h00);   wait_idle();
        issue(1'b0, 1'b0, 3'd1, 5'd0, 8'h00);   wait_idle();

`ifdef PBUF_ACCESS_WRITE_VERIFY_EN
        // Read-back corrupted in bit 0: write must raise err.
        corrupt = 1'b1;
        issue(1'b1, 1'b0, 3'd1, 5'd2, 8'h3C);
        wait_idle();
        corrupt = 1'b0;
        chk("verify_err_seen", 32'(err_pending), 0);
        issue(0, 0, 3'd1, 5'd0, 8'h00); wait_idle();
`endif

        // Reset during WAIT: everything back to reset values, no late response.
        issue(1'b0, 1'b0, 3'd1, 5'd5, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        exp_rsp.delete();
        exp_wr.delete();
        err_pending = 0;
        @(negedge clk);
        chk_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_bufp", 32'(bufp_out), 0);

        // Read after reset: buffer 0 already selected.
        issue(1'b0, 1'b0, 3'd0, 5'd19, 8'h00);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pbuf_access.md
PBUF_ACCESS -- requirements
Module: pbuf_access

Interface
REQ-001 Parameter BUF_SIZE, default 22, number of fields per pattern buffer.
REQ-002 Parameter BUF_WIDTH, default 8, field byte width.
REQ-003 Parameter NO_BUFS, default 8, number of pattern buffers.
REQ-004 Parameter READ_LAT, default 2, cycles from fieldp_out change to valid field_byte_in; legal range 1..7.
REQ-005 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1=write, 0=read.
- cmd_burst  in  1  read only: read fields cmd_field..BUF_SIZE-1.
- cmd_buf  in  3  buffer index.
- cmd_field  in  5  field index.
- cmd_data  in  BUF_WIDTH  write data.
- rsp_valid  out  1  one-cycle read-data strobe, no backpressure.
- rsp_data  out  BUF_WIDTH  read byte.
- rsp_field  out  5  field index of rsp_data.
- rsp_last  out  1  final response of the command.
- err  out  1  one-cycle error strobe.
- bufp_out  out  3  buffer pointer to pattern buffer.
- fieldp_out  out  BUF_SIZE  one-hot read field pointer.
- fieldwp_out  out  BUF_SIZE  one-hot write field pointer.
- field_out  out  BUF_WIDTH  write data.
- field_write_out  out  1  write strobe.
- field_byte_in  in  BUF_WIDTH  read byte returned by pattern buffer.

Function
REQ-006 FSM states IDLE, SETBUF, SETFLD, WAIT; cmd_ready SHALL be high only in IDLE.
REQ-007 IDLE, accept: latch command; cmd_field >= BUF_SIZE -> err pulse next cycle, no port activity, stay IDLE.
REQ-008 IDLE, accept, legal field: cmd_buf != bufp_out -> SETBUF; else -> SETFLD.
REQ-009 SETBUF: bufp_out <= latched buf, fieldp_out/fieldwp_out unchanged; -> SETFLD.
REQ-010 bufp_out and fieldp_out/fieldwp_out SHALL never change in the same cycle.
REQ-011 SETFLD write: fieldwp_out <= one-hot(field), field_out <= data, field_write_out high exactly one cycle; -> IDLE.
REQ-012 SETFLD read: fieldp_out <= one-hot(field), wait counter <= READ_LAT; -> WAIT.
REQ-013 WAIT: decrement counter; on expiry sample field_byte_in into rsp_data, pulse rsp_valid with rsp_field.
REQ-014 Burst with field < BUF_SIZE-1: field+1, -> SETFLD; otherwise rsp_last high with rsp_valid, -> IDLE.
REQ-015 Single read SHALL assert rsp_last on its only response.
REQ-016 Pointers (bufp_out, fieldp_out, fieldwp_out) SHALL hold their last value between commands.
REQ-017 Command issued while cmd_ready low SHALL be ignored.

Reset
REQ-018 Reset: FSM IDLE; bufp_out 0; fieldp_out, fieldwp_out, field_out 0; field_write_out, rsp_valid, rsp_last, err 0; rsp_data, rsp_field 0.
REQ-019 Reset mid-command SHALL drop the command with no further rsp_valid or field_write_out.

Configuration
REQ-020 Macro PBUF_ACCESS_WRITE_VERIFY_EN defined: after each write, set fieldp_out to the same one-hot field, wait READ_LAT, compare field_byte_in with written data; mismatch -> err pulse; no rsp_valid; cmd_ready low until done.
REQ-021 Macro undefined: write completes per REQ-011, fieldp_out untouched by writes.

Structure
REQ-022 Package pbuf_pkg SHALL hold field offsets (PDRIVE=0, NDRIVE=1, PTWEAKSENSE=2 .. PTWEAK7=11, NTWEAKSENSE=12 .. NTWEAK7=21), FSM state enum, field index width.
REQ-023 Sub-module pbuf_onehot: field index -> BUF_SIZE one-hot, all-zero when out of range.

Verification
REQ-024 After reset, write buf 3 field 5 data 0xA5 -> bufp_out=3 one cycle, next cycle fieldwp_out=bit5, field_out=0xA5, field_write_out one cycle.
REQ-025 Read buf 3 field 5 with READ_LAT=2, model returning 0xA5 -> rsp_valid, rsp_data=0xA5, rsp_field=5, rsp_last=1; no SETBUF cycle.
REQ-026 Burst read buf 0 from field 19 -> three responses fields 19,20,21, rsp_last only on 21; bufp_out constant.
REQ-027 Read field 22 -> err pulse, no pointer change, cmd_ready high again next cycle.
REQ-028 Reset asserted during WAIT -> all outputs at reset values, no rsp_valid afterward.
REQ-029 With PBUF_ACCESS_WRITE_VERIFY_EN, model corrupting bit 0 -> write 0x3C to field 2 gives err pulse after READ_LAT.
